// File: rtl/sync_send_bridge_pkg.sv
// Shared types and constants for the clocked-to-C-element send bridge.
// Holds the FSM encoding, reset values and parameter legal ranges.
package sync_send_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Both handshake phases restart at 0 with the C-element's RESETN.
  localparam logic SEND_RST  = 1'b0;
  localparam logic DATA_FILL = 1'b0;

  localparam int SETUP_MIN   = 1;
  localparam int SETUP_MAX   = 15;
  localparam int SYNC_MIN    = 2;
  localparam int SYNC_MAX    = 4;
  localparam int TIMEOUT_MIN = 2;
  localparam int TIMEOUT_MAX = 65535;

endpackage

// File: rtl/sync_send_bridge_ack_sync.sv
// ack_sync: STAGES-deep flop chain bringing an async level into the CP domain.
// Ports: clk, rst (async, active-high), d (async in), q (synchronized out).
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_send_bridge.sv
// Valid/ready stream to two-phase bundled-data request for a C-element stage.
// Ports: CP/RESET, IN_VALID/IN_READY/IN_DATA upstream, SENDOUT/DATAOUT/ACKIN
// to the C-element, XFER_COUNT, sticky TIMEOUT/PROTO_ERR, CLR_ERR.
module sync_send_bridge
  import sync_send_bridge_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SETUP_CYCLES   = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_W        = 16
) (
  input  logic               CP,
  input  logic               RESET,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   IN_DATA,
  output logic               SENDOUT,
  output logic [WIDTH-1:0]   DATAOUT,
  input  logic               ACKIN,
  output logic [COUNT_W-1:0] XFER_COUNT,
  output logic               TIMEOUT,
  output logic               PROTO_ERR,
  input  logic               CLR_ERR
);

  if (SETUP_CYCLES < SETUP_MIN || SETUP_CYCLES > SETUP_MAX) begin : g_bad_setup
    $error("SETUP_CYCLES out of range");
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (TIMEOUT_CYCLES < TIMEOUT_MIN || TIMEOUT_CYCLES > TIMEOUT_MAX) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES out of range");
  end

  localparam logic [3:0]  SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nx;
  logic               send_ph, send_nx;
  logic [WIDTH-1:0]   data_q, data_nx;
  logic [3:0]         setup_cnt, setup_nx;
  logic [15:0]        to_cnt, to_nx;
  logic [COUNT_W-1:0] xfer_q, xfer_nx;
  logic               to_flag, to_flag_nx;
  logic               perr, perr_nx;
  logic               to_set, perr_set;
  logic               ack_s;

  ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (CP),
    .rst (RESET),
    .d   (ACKIN),
    .q   (ack_s)
  );

  always_ff @(posedge CP or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      send_ph   <= SEND_RST;
      data_q    <= {WIDTH{DATA_FILL}};
      setup_cnt <= '0;
      to_cnt    <= '0;
      xfer_q    <= '0;
      to_flag   <= 1'b0;
      perr      <= 1'b0;
    end else begin
      state     <= state_nx;
      send_ph   <= send_nx;
      data_q    <= data_nx;
      setup_cnt <= setup_nx;
      to_cnt    <= to_nx;
      xfer_q    <= xfer_nx;
      to_flag   <= to_flag_nx;
      perr      <= perr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    send_nx  = send_ph;
    data_nx  = data_q;
    setup_nx = setup_cnt;
    to_nx    = to_cnt;
    xfer_nx  = xfer_q;
    to_set   = 1'b0;
    // Outside WAIT_ACK the phases must agree; any mismatch is a stray ack.
    perr_set = (state != WAIT_ACK) && (ack_s != send_ph);
    unique case (state)
      IDLE: begin
        if (IN_VALID) begin
          data_nx  = IN_DATA;
          setup_nx = SETUP_LOAD;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt == '0) begin
          send_nx  = ~send_ph;
          to_nx    = '0;
          state_nx = WAIT_ACK;
        end else begin
          setup_nx = setup_cnt - 4'd1;
        end
      end
      WAIT_ACK: begin
        if (ack_s == send_ph) begin
          xfer_nx  = xfer_q + 1'b1;
          to_nx    = '0;
          state_nx = IDLE;
        end else if (to_cnt == TO_LAST) begin
          to_set = 1'b1;
        end else begin
          to_nx = to_cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    to_flag_nx = to_set   | (to_flag & ~CLR_ERR);
    perr_nx    = perr_set | (perr & ~CLR_ERR);
  end

  assign IN_READY   = (state == IDLE) & ~RESET;
  assign SENDOUT    = send_ph;
  assign DATAOUT    = data_q;
  assign XFER_COUNT = xfer_q;
  assign TIMEOUT    = to_flag;
  assign PROTO_ERR  = perr;

endmodule

// File: tb/tb_sync_send_bridge.sv
// Scoreboard bench for sync_send_bridge with a behavioural C-element model.
// Main process drives words and acks; a monitor checks each SENDOUT edge.
module tb_sync_send_bridge;

  localparam int W     = 8;
  localparam int SETUP = 2;
  localparam int SYNC  = 2;
  localparam int TMO   = 16;
  localparam int CW    = 4;

  logic          CP = 1'b0;
  logic          RESET = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [W-1:0]  IN_DATA = '0;
  logic          SENDOUT;
  logic [W-1:0]  DATAOUT;
  logic          ACKIN = 1'b0;
  logic [CW-1:0] XFER_COUNT;
  logic          TIMEOUT;
  logic          PROTO_ERR;
  logic          CLR_ERR = 1'b0;

  sync_send_bridge #(
    .WIDTH          (W),
    .SETUP_CYCLES   (SETUP),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO),
    .COUNT_W        (CW)
  ) dut (
    .CP         (CP),
    .RESET      (RESET),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_DATA    (IN_DATA),
    .SENDOUT    (SENDOUT),
    .DATAOUT    (DATAOUT),
    .ACKIN      (ACKIN),
    .XFER_COUNT (XFER_COUNT),
    .TIMEOUT    (TIMEOUT),
    .PROTO_ERR  (PROTO_ERR),
    .CLR_ERR    (CLR_ERR)
  );

  always #5 CP = ~CP;

  int cyc = 0;
  always @(posedge CP) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         ph;
    int           acc;
  } exp_t;

  exp_t sbq[$];

  // Reference model: phase flips per accepted word, count wraps mod 2^CW.
  logic m_ph = 1'b0;
  int   m_cnt = 0;

  // Monitor: every SENDOUT edge is a presented request.
  logic         prev_send = 1'b0;
  logic [W-1:0] held;
  logic         busy = 1'b0;
  logic         stable_ok = 1'b1;
  exp_t         mon_e;

  initial begin
    forever begin
      @(negedge CP);
      if (RESET) begin
        prev_send = 1'b0;
        busy      = 1'b0;
        sbq.delete();
      end else if (SENDOUT !== prev_send) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sendout actual=%0b", SENDOUT);
        end else begin
          mon_e = sbq.pop_front();
          chk("dataout", DATAOUT, mon_e.data);
          chk("phase", SENDOUT, mon_e.ph);
          chk("setup_lat", cyc - mon_e.acc, SETUP);
          held      = DATAOUT;
          stable_ok = 1'b1;
          busy      = 1'b1;
        end
        prev_send = SENDOUT;
      end else if (busy) begin
        if (DATAOUT !== held) stable_ok = 1'b0;
        if (IN_READY) begin
          chk("data_stable", stable_ok, 1);
          busy = 1'b0;
        end
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, output int sc);
    int n;
    n = 0;
    @(negedge CP);
    while (!IN_READY && n < 50) begin
      @(negedge CP);
      n++;
    end
    chk("ready_wait", IN_READY, 1);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    m_ph     = ~m_ph;
    sbq.push_back('{d, m_ph, cyc + 1});
    @(negedge CP);
    IN_VALID = 1'b0;
    IN_DATA  = W'($urandom);
    chk("dataout_acc", DATAOUT, d);
    chk("ready_low", IN_READY, 0);
    n = 0;
    while (SENDOUT !== m_ph && n < 50) begin
      @(negedge CP);
      n++;
    end
    chk("sendout_edge", SENDOUT, m_ph);
    sc = cyc;
  endtask

  task automatic ack_done(input int delay);
    int c;
    int n;
    repeat (delay) @(negedge CP);
    ACKIN = m_ph;
    c = cyc;
    n = 0;
    do begin
      @(negedge CP);
      n++;
    end while (!IN_READY && n < 40);
    chk("ack_lat", cyc - c, SYNC + 1);
    m_cnt = (m_cnt + 1) % (1 << CW);
    chk("xfer_count", XFER_COUNT, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge CP);
    RESET = 1'b1;
    ACKIN = 1'b0;
    m_ph  = 1'b0;
    m_cnt = 0;
    repeat (2) @(negedge CP);
    RESET = 1'b0;
  endtask

  int sc;

  initial begin
    // Reset held with activity on the inputs.
    IN_VALID = 1'b1;
    IN_DATA  = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      @(negedge CP);
      ACKIN = ~ACKIN;
    end
    #1;
    chk("rst_sendout", SENDOUT, 0);
    chk("rst_dataout", DATAOUT, 0);
    chk("rst_ready", IN_READY, 0);
    chk("rst_count", XFER_COUNT, 0);
    chk("rst_flags", {TIMEOUT, PROTO_ERR}, 0);
    IN_VALID = 1'b0;
    @(negedge CP);
    RESET = 1'b0;

    // Single transfer.
    send_word(8'hA5, sc);
    ack_done(3);

    // Four-word stream, ack 3 cycles after each request edge.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send_word(W'(i), sc);
      ack_done(3);
    end
    chk("stream_count", XFER_COUNT, 4);

    // Random stream with random ack latency.
    for (int i = 0; i < 12; i++) begin
      send_word(W'($urandom), sc);
      ack_done(int'($urandom_range(0, 5)));
    end
    chk("no_tmo", TIMEOUT, 0);
    chk("no_perr", PROTO_ERR, 0);

    // Timeout with the ack withheld, then a late ack.
    do_reset();
    send_word(W'($urandom), sc);
    repeat (TMO - 1) @(negedge CP);
    chk("tmo_early", TIMEOUT, 0);
    @(negedge CP);
    chk("tmo_set", TIMEOUT, 1);
    repeat (10) @(negedge CP);
    chk("single_toggle", SENDOUT, m_ph);
    ack_done(0);
    chk("tmo_sticky", TIMEOUT, 1);
    CLR_ERR = 1'b1;
    @(negedge CP);
    CLR_ERR = 1'b0;
    chk("tmo_clr", TIMEOUT, 0);

    // Spurious ack while idle.
    ACKIN = ~ACKIN;
    repeat (SYNC) @(negedge CP);
    chk("perr_early", PROTO_ERR, 0);
    @(negedge CP);
    chk("perr_set", PROTO_ERR, 1);
    ACKIN = m_ph;
    repeat (4) @(negedge CP);
    CLR_ERR = 1'b1;
    @(negedge CP);
    CLR_ERR = 1'b0;
    chk("perr_clr", PROTO_ERR, 0);
    CLR_ERR = 1'b1;
    ACKIN   = ~ACKIN;
    repeat (5) @(negedge CP);
    CLR_ERR = 1'b0;
    chk("perr_set_wins", PROTO_ERR, 1);
    ACKIN = m_ph;
    repeat (4) @(negedge CP);
    CLR_ERR = 1'b1;
    @(negedge CP);
    CLR_ERR = 1'b0;
    chk("perr_clr2", PROTO_ERR, 0);

    // Reset in the middle of WAIT_ACK.
    send_word(W'($urandom), sc);
    @(negedge CP);
    #2;
    RESET = 1'b1;
    #1;
    chk("mid_sendout", SENDOUT, 0);
    chk("mid_dataout", DATAOUT, 0);
    chk("mid_ready", IN_READY, 0);
    chk("mid_count", XFER_COUNT, 0);
    ACKIN = 1'b0;
    m_ph  = 1'b0;
    m_cnt = 0;
    repeat (2) @(negedge CP);
    RESET = 1'b0;
    send_word(W'($urandom), sc);
    ack_done(2);
    chk("post_rst_count", XFER_COUNT, 1);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < (1 << CW); i++) begin
      send_word(W'($urandom), sc);
      ack_done(int'($urandom_range(0, 3)));
    end
    chk("wrap", XFER_COUNT, 0);
    chk("wrap_flags", {TIMEOUT, PROTO_ERR}, 0);

    repeat (3) @(negedge CP);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
